// File: rtl/hiscore_upload.sv
// rtl/hiscore_upload.sv - serves HPS upload reads of the high-score RAM region
// Optional HS_CHECKSUM_EN: a read at addr == DEPTH returns the session's running byte sum.

module hiscore_upload #(
   parameter logic [7:0] INDEX   = 8'd4,
   parameter int         RAM_AW  = 10,
   parameter int         DEPTH   = 1024,
   parameter int         TIMEOUT = 255
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_upload,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_rd,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   output logic              pause_cpu,
   input  logic              pause_ack,
   output logic              ram_req,
   output logic [RAM_AW-1:0] ram_address,
   input  logic              ram_grant,
   input  logic [7:0]        ram_q,
   output logic              err
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARM     = 3'd1;
   localparam logic [2:0] S_READY   = 3'd2;
   localparam logic [2:0] S_FETCH   = 3'd3;
   localparam logic [2:0] S_CAPTURE = 3'd4;

   localparam logic [1:0] K_RAM = 2'd0;
   localparam logic [1:0] K_FF  = 2'd1;
   localparam logic [1:0] K_SUM = 2'd2;

   localparam int              CW       = $clog2(TIMEOUT + 1);
   localparam logic [24:0]     DEPTH_A  = 25'(DEPTH);
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

   logic [2:0]        state_q, state_d;
   logic              sel, sel_q;
   logic              pause_q, pause_d;
   logic              err_q, err_d;
   logic [7:0]        din_q, din_d;
   logic [RAM_AW-1:0] addr_q, addr_d;
   logic [1:0]        kind_q, kind_d;
   logic              pend_q, pend_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              forced_q, forced_d;
   logic [7:0]        fval_q, fval_d;
   logic [1:0]        rd_kind;
   logic [RAM_AW-1:0] rd_addr;
   logic [7:0]        sum_val;

`ifdef HS_CHECKSUM_EN
   logic [7:0]        sum_q, sum_d;
   logic              inr_q, inr_d;
   assign sum_val = sum_q;
`else
   assign sum_val = 8'hFF;
`endif

   // Full 25-bit compare so high address bits never alias into RAM.
   function automatic logic [1:0] classify(input logic [24:0] a);
      if (a < DEPTH_A) return K_RAM;
`ifdef HS_CHECKSUM_EN
      if (a == DEPTH_A) return K_SUM;
`endif
      return K_FF;
   endfunction

   assign sel         = ioctl_upload & (ioctl_index == INDEX);
   assign ram_req     = (state_q == S_FETCH) & pause_ack & sel;
   assign ram_address = addr_q;
   assign ioctl_din   = din_q;
   assign pause_cpu   = pause_q;
   assign err         = err_q;
   assign ioctl_wait  = (ioctl_rd & sel) | (state_q == S_ARM) | (state_q == S_FETCH) |
                        (state_q == S_CAPTURE) | ((state_q == S_READY) & pend_q);

   always_comb begin
      state_d  = state_q;
      pause_d  = pause_q;
      err_d    = err_q;
      din_d    = din_q;
      addr_d   = addr_q;
      kind_d   = kind_q;
      pend_d   = pend_q;
      cnt_d    = cnt_q;
      forced_d = forced_q;
      fval_d   = fval_q;
      rd_kind  = kind_q;
      rd_addr  = addr_q;
`ifdef HS_CHECKSUM_EN
      sum_d    = sum_q;
      inr_d    = inr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (sel & ~sel_q) begin
               state_d = S_ARM;
               pause_d = 1'b1;
               err_d   = 1'b0;
               pend_d  = 1'b0;
`ifdef HS_CHECKSUM_EN
               sum_d   = 8'h00;
`endif
            end
         end
         S_ARM: begin
            if (ioctl_rd) begin
               pend_d = 1'b1;
               addr_d = ioctl_addr[RAM_AW-1:0];
               kind_d = classify(ioctl_addr);
            end
            if (pause_ack) state_d = S_READY;
         end
         S_READY: begin
            if (ioctl_rd) begin
               rd_kind = classify(ioctl_addr);
               rd_addr = ioctl_addr[RAM_AW-1:0];
            end
            if (ioctl_rd | pend_q) begin
               pend_d   = 1'b0;
               addr_d   = rd_addr;
               cnt_d    = '0;
               forced_d = 1'b1;
               fval_d   = 8'hFF;
               state_d  = S_CAPTURE;
`ifdef HS_CHECKSUM_EN
               inr_d    = 1'b0;
`endif
               if (rd_kind == K_RAM) begin
                  state_d  = S_FETCH;
                  forced_d = 1'b0;
`ifdef HS_CHECKSUM_EN
                  inr_d    = 1'b1;
`endif
               end else if (rd_kind == K_SUM) begin
                  fval_d = sum_val;
               end
            end
         end
         S_FETCH: begin
            if (ram_req & ram_grant) begin
               state_d  = S_CAPTURE;
               forced_d = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = S_CAPTURE;
               forced_d = 1'b1;
               fval_d   = 8'hFF;
               err_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CAPTURE: begin
            din_d   = forced_q ? fval_q : ram_q;
            state_d = S_READY;
`ifdef HS_CHECKSUM_EN
            if (inr_q) sum_d = sum_q + din_d;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      // Losing the session abandons whatever is in flight; ioctl_din keeps its last value.
      if (!sel) begin
         state_d = S_IDLE;
         pause_d = 1'b0;
         pend_d  = 1'b0;
         din_d   = din_q;
`ifdef HS_CHECKSUM_EN
         sum_d   = sum_q;
`endif
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         // Reset to 1 so a session already selected across reset is not re-armed.
         sel_q    <= 1'b1;
         pause_q  <= 1'b0;
         err_q    <= 1'b0;
         din_q    <= 8'h00;
         addr_q   <= '0;
         kind_q   <= K_RAM;
         pend_q   <= 1'b0;
         cnt_q    <= '0;
         forced_q <= 1'b0;
         fval_q   <= 8'h00;
`ifdef HS_CHECKSUM_EN
         sum_q    <= 8'h00;
         inr_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sel_q    <= sel;
         pause_q  <= pause_d;
         err_q    <= err_d;
         din_q    <= din_d;
         addr_q   <= addr_d;
         kind_q   <= kind_d;
         pend_q   <= pend_d;
         cnt_q    <= cnt_d;
         forced_q <= forced_d;
         fval_q   <= fval_d;
`ifdef HS_CHECKSUM_EN
         sum_q    <= sum_d;
         inr_q    <= inr_d;
`endif
      end
   end

endmodule

// File: tb/tb_hiscore_upload.sv
// tb/tb_hiscore_upload.sv - self-checking bench for hiscore_upload
// RAM and pause_ack are modelled here; expected bytes flow through a scoreboard queue.

module tb_hiscore_upload;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ioctl_upload;
   logic [7:0]  ioctl_index;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic        pause_cpu;
   logic        pause_ack;
   logic        ram_req;
   logic [9:0]  ram_address;
   logic        ram_grant;
   logic [7:0]  ram_q = 8'h00;
   logic        err;

   always #5 clk_sys = ~clk_sys;

   hiscore_upload dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .ioctl_upload (ioctl_upload),
      .ioctl_index  (ioctl_index),
      .ioctl_rd     (ioctl_rd),
      .ioctl_addr   (ioctl_addr),
      .ioctl_din    (ioctl_din),
      .ioctl_wait   (ioctl_wait),
      .pause_cpu    (pause_cpu),
      .pause_ack    (pause_ack),
      .ram_req      (ram_req),
      .ram_address  (ram_address),
      .ram_grant    (ram_grant),
      .ram_q        (ram_q),
      .err          (err)
   );

   logic [7:0] mem [0:1023];
   int   gnt_delay  = 0;
   logic gnt_block  = 1'b0;
   int   req_cnt    = 0;
   int   ack_delay  = 5;
   int   ack_cnt    = 0;
   int   req_cycles = 0;
   int   viol       = 0;
   int   checks     = 0;
   int   errors     = 0;
   logic [7:0] exp_q [$];

   assign pause_ack = pause_cpu && (ack_cnt >= ack_delay);
   assign ram_grant = ram_req && !gnt_block && (req_cnt >= gnt_delay);

   always @(posedge clk_sys) begin
      req_cnt <= ram_req ? req_cnt + 1 : 0;
      ack_cnt <= pause_cpu ? ack_cnt + 1 : 0;
      ram_q   <= ram_grant ? mem[ram_address] : 8'hEE;
   end

   always @(negedge clk_sys) begin
      if (ram_req) req_cycles++;
      if (ram_req && !pause_ack) viol++;
   end

   typedef struct {
      logic [24:0] addr;
      int          dly;
      logic [7:0]  exp_din;
      int          exp_wait;
      bit          in_range;
   } vec_t;
   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_read(input logic [24:0] a, input logic [7:0] exp_din,
                          input int exp_wait, input string name);
      int n;
      n = 0;
      @(negedge clk_sys);
      ioctl_rd   = 1'b1;
      ioctl_addr = a;
      exp_q.push_back(exp_din);
      #1;
      while (ioctl_wait && n < 2000) begin
         n++;
         @(negedge clk_sys);
         ioctl_rd = 1'b0;
         #1;
      end
      ioctl_rd = 1'b0;
      check({name, "_din"}, ioctl_din, exp_q.pop_front());
      if (exp_wait >= 0) check({name, "_wait"}, n, exp_wait);
   endtask

   task automatic start_session(input int dly);
      int n;
      n = 0;
      ack_delay = dly;
      @(negedge clk_sys);
      ioctl_index  = 8'd4;
      ioctl_upload = 1'b1;
      @(negedge clk_sys);
      #1;
      while (!(pause_ack && !ioctl_wait) && n < 200) begin
         @(negedge clk_sys);
         #1;
         n++;
      end
      check("session_ready", (n < 200), 1);
      check("session_pause", pause_cpu, 1);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      int bad;
      int n;

      reset_n      = 1'b0;
      ioctl_upload = 1'b0;
      ioctl_index  = 8'd0;
      ioctl_rd     = 1'b0;
      ioctl_addr   = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 3));
      mem[10'h010] = 8'h5A;
      mem[10'h020] = 8'h33;
      mem[10'h0F0] = 8'h93;

      vecs[0] = '{25'h0000010, 0, mem[10'h010], 3, 1'b1};
      vecs[1] = '{25'h0000020, 2, mem[10'h020], 5, 1'b1};
      vecs[2] = '{25'h00000F0, 0, mem[10'h0F0], 3, 1'b1};
`ifdef HS_CHECKSUM_EN
      vecs[3] = '{25'h0000400, 0, 8'h20, 2, 1'b0};
`else
      vecs[3] = '{25'h0000400, 0, 8'hFF, 2, 1'b0};
`endif
      vecs[4] = '{25'h00003FF, 1, mem[10'h3FF], 4, 1'b1};
      vecs[5] = '{25'h1000010, 0, 8'hFF, 2, 1'b0};
      vecs[6] = '{25'h0000401, 0, 8'hFF, 2, 1'b0};

      repeat (3) @(negedge clk_sys);
      #1;
      check("rst_pause", pause_cpu, 0);
      check("rst_req", ram_req, 0);
      check("rst_wait", ioctl_wait, 0);
      check("rst_din", ioctl_din, 0);
      check("rst_err", err, 0);
      check("rst_addr", ram_address, 0);
      @(negedge clk_sys);
      reset_n = 1'b1;

      ioctl_index  = 8'd3;
      ioctl_upload = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_sys);
         ioctl_rd   = (i % 4 == 1);
         ioctl_addr = 25'h10;
         #1;
         if (pause_cpu || ram_req || ioctl_wait) bad++;
      end
      ioctl_rd = 1'b0;
      check("wrong_index_quiet", bad, 0);
      ioctl_upload = 1'b0;
      repeat (2) @(negedge clk_sys);

      start_session(5);
      for (int i = 0; i < 7; i++) begin
         gnt_delay = vecs[i].dly;
         r0 = req_cycles;
         do_read(vecs[i].addr, vecs[i].exp_din, vecs[i].exp_wait, $sformatf("vec%0d", i));
         if (!vecs[i].in_range) check($sformatf("vec%0d_noram", i), req_cycles - r0, 0);
      end
      gnt_delay = 0;
      check("err_clean", err, 0);

      gnt_block = 1'b1;
      do_read(25'h20, 8'hFF, 257, "timeout");
      check("timeout_err", err, 1);
      check("timeout_req_drop", ram_req, 0);

      @(negedge clk_sys);
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'h20;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      repeat (5) @(negedge clk_sys);
      #1;
      check("drop_in_fetch", ram_req, 1);
      @(negedge clk_sys);
      ioctl_upload = 1'b0;
      @(negedge clk_sys);
      #1;
      check("drop_pause", pause_cpu, 0);
      check("drop_req", ram_req, 0);
      check("drop_wait", ioctl_wait, 0);
      check("drop_din_hold", ioctl_din, 8'hFF);
      gnt_block = 1'b0;
      repeat (2) @(negedge clk_sys);
      start_session(2);
      check("new_session_err", err, 0);

      ioctl_upload = 1'b0;
      repeat (2) @(negedge clk_sys);
      ack_delay = 6;
      ioctl_upload = 1'b1;
      @(negedge clk_sys);
      @(negedge clk_sys);
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'h10;
      exp_q.push_back(mem[10'h010]);
      #1;
      check("pending_in_arm", pause_ack, 0);
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      n = 0;
      #1;
      while (ioctl_wait && n < 200) begin
         @(negedge clk_sys);
         #1;
         n++;
      end
      check("pending_done", (n < 200), 1);
      check("pending_din", ioctl_din, exp_q.pop_front());

      gnt_block = 1'b1;
      @(negedge clk_sys);
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'h30;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      repeat (3) @(negedge clk_sys);
      reset_n = 1'b0;
      #1;
      check("arst_req", ram_req, 0);
      check("arst_pause", pause_cpu, 0);
      check("arst_wait", ioctl_wait, 0);
      check("arst_din", ioctl_din, 0);
      check("arst_err", err, 0);
      r0 = req_cycles;
      repeat (2) @(negedge clk_sys);
      reset_n   = 1'b1;
      gnt_block = 1'b0;
      repeat (20) @(negedge clk_sys);
      check("arst_no_req", req_cycles - r0, 0);
      ioctl_upload = 1'b0;
      repeat (2) @(negedge clk_sys);
      start_session(1);
      do_read(25'h10, mem[10'h010], 3, "after_reset");

      check("req_without_ack", viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
